// File: rtl/gpu_prefetch_ctrl.sv
// gpu_prefetch_ctrl
//   Instruction prefetch controller for the GPU front end. Reads 32-bit
//   longwords from local memory over a req/ack handshake, splits them into
//   big-endian halfwords held in a 4-entry queue, and presents the head
//   halfword plus its byte address to the instruction decoder.
//
// Ports
//   clk          system clock, all state on the rising edge
//   resetl       asynchronous active-low reset
//   jump         one-cycle pulse: restart fetching at jump_addr
//   jump_addr    jump target byte address (bit 0 ignored)
//   fetch_req    memory read request, held until fetch_ack
//   fetch_addr   longword-aligned read address
//   fetch_ack    read complete, fetch_data valid this cycle
//   fetch_data   read data, bits 31:16 are the lower-addressed halfword
//   instr_valid  queue head is valid
//   instr        queue head halfword
//   instr_pc     byte address of instr
//   instr_take   decoder consumes the head halfword
module gpu_prefetch_ctrl #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  output logic          fetch_req,
  output logic [AW-1:0] fetch_addr,
  input  logic          fetch_ack,
  input  logic [31:0]   fetch_data,
  output logic          instr_valid,
  output logic [15:0]   instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_take
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] tgt_q, tgt_d;        // jump target parked while draining a stale request
  logic          skip_q, skip_d;      // first fetched halfword lies before the jump target
  logic [15:0]   mem_q [4];

  logic          pop;
  logic          accept;
  logic [2:0]    enq_n;
  logic [1:0]    wr0_ptr;
  logic [1:0]    wr1_ptr;
  logic [AW-1:0] jump_aligned;

  // Bit 0 of the jump target addresses a byte inside a halfword; never used.
  logic unused_jump_bit0;
  assign unused_jump_bit0 = jump_addr[0];

  assign jump_aligned = {jump_addr[AW-1:2], 2'b00};
  assign pop          = instr_take && (count_q != 3'd0);
  // A jump in the same cycle as the ack turns the returned data stale.
  assign accept       = (state_q == FETCH) && fetch_ack && !jump;
  assign enq_n        = accept ? (skip_q ? 3'd1 : 3'd2) : 3'd0;

  // Requests only start with count <= 2, so rd_ptr + count never laps the
  // head when two halfwords are written.
  assign wr0_ptr = rd_ptr_q + count_q[1:0];
  assign wr1_ptr = wr0_ptr + 2'd1;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_addr_d = fetch_addr_q;
    tgt_d        = tgt_q;
    skip_d       = skip_q;

    unique case (state_q)
      IDLE: begin
        if (!jump && count_q <= 3'd2) state_d = FETCH;
      end
      FETCH: begin
        if (fetch_ack)  state_d = IDLE;
        else if (jump)  state_d = DISCARD;
      end
      DISCARD: begin
        if (fetch_ack) begin
          state_d      = IDLE;
          fetch_addr_d = tgt_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      fetch_addr_d = fetch_addr_q + {{(AW-3){1'b0}}, 3'd4};
      skip_d       = 1'b0;
    end

    count_d  = count_q + enq_n - {2'b00, pop};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};

    if (jump) begin
      count_d = 3'd0;
      tgt_d   = jump_aligned;
      skip_d  = jump_addr[1];
      // An unacked request must keep its address on the bus; the new
      // target is loaded from tgt_q when that request finally completes.
      if (!((state_q == FETCH || state_q == DISCARD) && !fetch_ack))
        fetch_addr_d = jump_aligned;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q      <= IDLE;
      count_q      <= 3'd0;
      rd_ptr_q     <= 2'd0;
      fetch_addr_q <= '0;
      tgt_q        <= '0;
      skip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      tgt_q        <= tgt_d;
      skip_q       <= skip_d;
    end
  end

  // Queue storage: one register per entry. The first write slot receives the
  // upper halfword unless the upper halfword is being skipped.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
      logic we0;
      logic we1;
      assign we0 = accept && (wr0_ptr == 2'(gi));
      assign we1 = accept && !skip_q && (wr1_ptr == 2'(gi));

      always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
          mem_q[gi] <= 16'h0000;
        end else if (we0) begin
          mem_q[gi] <= skip_q ? fetch_data[15:0] : fetch_data[31:16];
        end else if (we1) begin
          mem_q[gi] <= fetch_data[15:0];
        end
      end
    end
  endgenerate

  assign fetch_req   = (state_q != IDLE);
  assign fetch_addr  = fetch_addr_q;
  assign instr_valid = (count_q != 3'd0);
  assign instr       = instr_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign instr_pc    = fetch_addr_q - {{(AW-4){1'b0}}, count_q, 1'b0};

endmodule

// File: tb/tb_gpu_prefetch_ctrl.sv
module tb_gpu_prefetch_ctrl;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          resetl;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [31:0]   fetch_data;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_take;

  gpu_prefetch_ctrl #(.AW(AW)) dut (
    .clk         (clk),
    .resetl      (resetl),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_data  (fetch_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_take  (instr_take)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   d;
    logic [AW-1:0] pc;
  } ent_t;

  // Scoreboard: halfwords the decoder should see, in program order.
  ent_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [AW-1:0] exp_next;    // address the next fresh request must use
  logic          m_skip;      // next accepted longword contributes only its low half
  logic          discard;     // the outstanding request predates the last jump
  logic          req_seen;    // a request is outstanding
  logic [AW-1:0] req_cap;     // address the outstanding request was issued with
  int            delay;
  logic          prev_idle_ok;

  // Inputs applied at the last edge
  logic          a_jump, a_ack, a_req;
  logic [AW-1:0] a_jaddr;
  logic [31:0]   a_data;

  function automatic logic [AW-1:0] pick_target();
    case ($urandom_range(0, 5))
      0: return 24'h000100;
      1: return 24'h000102;
      2: return 24'h000200;
      3: return 24'hFFFFFC;
      4: return 24'hFFFFFE;
      default: return AW'($urandom);
    endcase
  endfunction

  // Monitor: compares the presented head against the scoreboard.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      check("instr_valid", {31'd0, instr_valid}, {31'd0, (sb.size() != 0)});
      if (resetl && instr_valid && instr_take && !jump && sb.size() != 0) begin
        e = sb.pop_front();
        check("instr", {16'd0, instr}, {16'd0, e.d});
        check("instr_pc", {8'd0, instr_pc}, {8'd0, e.pc});
        $display("pop instr=%h pc=%h", instr, instr_pc);
      end
    end
  end

  initial begin
    int take_pct;
    logic rst_pending;
    resetl     = 1'b0;
    jump       = 1'b0;
    jump_addr  = '0;
    fetch_ack  = 1'b0;
    fetch_data = '0;
    instr_take = 1'b0;
    exp_next = '0; m_skip = 1'b0; discard = 1'b0; req_seen = 1'b0; req_cap = '0;
    delay = 0; prev_idle_ok = 1'b0;
    a_jump = 1'b0; a_ack = 1'b0; a_req = 1'b0; a_jaddr = '0; a_data = '0;
    take_pct = 50; rst_pending = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    check("rst_fetch_addr", {8'd0, fetch_addr}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_instr_pc", {8'd0, instr_pc}, 32'd0);
    resetl = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);

      // Advance the reference model by the edge that just passed.
      if (a_req && a_ack) req_seen = 1'b0;
      if (a_jump) begin
        sb.delete();
        exp_next = {a_jaddr[AW-1:2], 2'b00};
        m_skip   = a_jaddr[1];
        discard  = a_req && !a_ack;
      end else if (a_req && a_ack) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          if (!m_skip) sb.push_back({a_data[31:16], exp_next});
          sb.push_back({a_data[15:0], exp_next + 24'd2});
          m_skip   = 1'b0;
          exp_next = exp_next + 24'd4;
        end
      end

      if (cyc % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: take_pct = 0;
          1: take_pct = 30;
          2: take_pct = 70;
          default: take_pct = 100;
        endcase
      end
      if (cyc == 1500 || cyc == 3000) rst_pending = 1'b1;

      // Reset pulse in the middle of an outstanding request.
      if (rst_pending && req_seen) begin
        rst_pending = 1'b0;
        resetl = 1'b0; jump = 1'b0; fetch_ack = 1'b0; instr_take = 1'b0;
        #1;
        check("midrst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("midrst_fetch_addr", {8'd0, fetch_addr}, 32'd0);
        check("midrst_instr_valid", {31'd0, instr_valid}, 32'd0);
        $display("reset pulse during request at cycle %0d", cyc);
        sb.delete();
        exp_next = '0; m_skip = 1'b0; discard = 1'b0; req_seen = 1'b0; prev_idle_ok = 1'b0;
        @(negedge clk);
        resetl = 1'b1;
        // A stray ack right after reset must be ignored.
        fetch_ack = 1'b1; fetch_data = 32'hDEADBEEF;
        a_jump = 1'b0; a_ack = 1'b1; a_req = 1'b0; a_data = fetch_data;
        continue;
      end

      // An idle controller with room for a longword must request right away.
      if (!a_jump && prev_idle_ok) check("req_start", {31'd0, fetch_req}, 32'd1);

      // Memory responder.
      if (fetch_req && !req_seen) begin
        check("req_addr", {8'd0, fetch_addr}, {8'd0, exp_next});
        check("req_room", {31'd0, (sb.size() <= 2)}, 32'd1);
        $display("req addr=%h queued=%0d", fetch_addr, sb.size());
        req_seen = 1'b1;
        req_cap  = fetch_addr;
        delay    = $urandom_range(0, 3);
      end else if (req_seen) begin
        check("req_hold", {31'd0, fetch_req}, 32'd1);
      end
      prev_idle_ok = !fetch_req && (sb.size() <= 2);

      jump       = ($urandom_range(0, 99) < 4);
      jump_addr  = pick_target();
      instr_take = ($urandom_range(0, 99) < take_pct);
      fetch_ack  = 1'b0;
      fetch_data = $urandom;
      if (req_seen) begin
        if (delay == 0) begin
          fetch_ack = 1'b1;
          check("ack_addr_stable", {8'd0, fetch_addr}, {8'd0, req_cap});
          $display("ack addr=%h data=%h jump=%0d stale=%0d", fetch_addr, fetch_data, jump, discard);
        end else begin
          delay--;
        end
      end
      if (jump) $display("jump to %h", jump_addr);

      a_jump = jump; a_jaddr = jump_addr; a_ack = fetch_ack; a_data = fetch_data; a_req = req_seen;
    end

    @(negedge clk);
    jump = 1'b0; fetch_ack = 1'b0; instr_take = 1'b0;
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
